// File: rtl/telemetry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_pkg
// Description : Shared types and constants for the telemetry frame scheduler:
//               default header tag, FSM state encoding, frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package telemetry_pkg;

  // Default frame header tag placed in the upper half of word 0
  localparam logic [15:0] c_MAGIC_DEFAULT = 16'h4E1C;

  // Frame scheduler states: idle, header word, counter word, channel words
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_CNT  = 2'd2,
    S_CH   = 2'd3
  } state_t;

  // Words per frame: header + counter snapshot + one word per channel
  function automatic int frame_words(input int n_ch);
    return n_ch + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/telemetry_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_frame_scheduler_if
// Description : 32-bit valid/ready output stream carrying telemetry frames.
// Revision    : 1.0 - initial release
// ============================================================================
interface telemetry_frame_scheduler_if;

  logic [31:0] m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tlast_o;
  logic        m_tready_i;

  modport master (
    output m_tdata_o,
    output m_tvalid_o,
    output m_tlast_o,
    input  m_tready_i
  );

  modport slave (
    input  m_tdata_o,
    input  m_tvalid_o,
    input  m_tlast_o,
    output m_tready_i
  );

endinterface
`default_nettype wire

// File: rtl/telemetry_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_frame_scheduler
// Description : Snapshots a channel vector and sample counter on each accepted
//               strobe and streams it as a framed packet (header, counter,
//               channels). One pending slot absorbs a sample arriving during
//               an active frame; further samples are counted as drops.
// Revision    : 1.0 - initial release
// ============================================================================
module telemetry_frame_scheduler
  import telemetry_pkg::*;
#(
  parameter int          N_CH  = 22,
  parameter logic [15:0] MAGIC = c_MAGIC_DEFAULT
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 enable_i,
  input  wire logic                 sample_valid_i,
  input  wire logic [N_CH*32-1:0]   ch_data_i,
  input  wire logic [31:0]          counter_i,
  telemetry_frame_scheduler_if.master m_axis,
  output logic [31:0]               frames_sent_o,
  output logic [15:0]               frames_dropped_o,
  output logic                      busy_o
);

  localparam int                c_IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_CH - 1);
  localparam logic [7:0]         c_NCH8     = 8'(N_CH);

  state_t                r_state;
  logic [c_IDX_W-1:0]    r_idx;
  logic [7:0]            r_seq;
  logic [N_CH*32-1:0]    r_act_ch;
  logic [31:0]           r_act_cnt;
  logic [N_CH*32-1:0]    r_pend_ch;
  logic [31:0]           r_pend_cnt;
  logic                  r_pend_full;
  logic [31:0]           r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [31:0]           r_sent;
  logic [15:0]           r_dropped;

  logic                  w_accept;
  logic                  w_hs;
  logic                  w_last_hs;
  logic [31:0]           w_header;
  logic [c_IDX_W-1:0]    w_idx_next;
  logic [31:0]           w_words [N_CH];

  assign w_accept   = enable_i & sample_valid_i;
  assign w_hs       = r_tvalid & m_axis.m_tready_i;
  assign w_last_hs  = w_hs & (r_state == S_CH) & (r_idx == c_LAST_IDX);
  assign w_header   = {MAGIC, c_NCH8, r_seq};
  assign w_idx_next = r_idx + c_IDX_W'(1);

  // Channel word view of the active snapshot; the output mux reads only this
  for (genvar k = 0; k < N_CH; k++) begin : g_words
    assign w_words[k] = r_act_ch[32*k +: 32];
  end

  assign m_axis.m_tdata_o  = r_tdata;
  assign m_axis.m_tvalid_o = r_tvalid;
  assign m_axis.m_tlast_o  = r_tlast;
  assign frames_sent_o     = r_sent;
  assign frames_dropped_o  = r_dropped;
  assign busy_o            = (r_state != S_IDLE) | r_pend_full;

  // Frame FSM with registered stream outputs, pending slot and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_seq       <= 8'd0;
      r_act_ch    <= '0;
      r_act_cnt   <= 32'd0;
      r_pend_ch   <= '0;
      r_pend_cnt  <= 32'd0;
      r_pend_full <= 1'b0;
      r_tdata     <= 32'd0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_sent      <= 32'd0;
      r_dropped   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_act_ch  <= ch_data_i;
            r_act_cnt <= counter_i;
            r_tdata   <= w_header;
            r_tvalid  <= 1'b1;
            r_tlast   <= 1'b0;
            r_seq     <= r_seq + 8'd1;
            r_state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_hs) begin
            r_tdata <= r_act_cnt;
            r_state <= S_CNT;
          end
        end
        S_CNT: begin
          if (w_hs) begin
            r_idx   <= '0;
            r_tdata <= w_words[0];
            r_tlast <= (N_CH == 1);
            r_state <= S_CH;
          end
        end
        S_CH: begin
          if (w_last_hs) begin
            r_sent <= r_sent + 32'd1;
            if (r_pend_full || w_accept) begin
              // Next frame starts straight away so tvalid never drops
              if (r_pend_full) begin
                r_act_ch    <= r_pend_ch;
                r_act_cnt   <= r_pend_cnt;
                r_pend_full <= w_accept;
                if (w_accept) begin
                  r_pend_ch  <= ch_data_i;
                  r_pend_cnt <= counter_i;
                end
              end else begin
                r_act_ch  <= ch_data_i;
                r_act_cnt <= counter_i;
              end
              r_tdata  <= w_header;
              r_tvalid <= 1'b1;
              r_tlast  <= 1'b0;
              r_seq    <= r_seq + 8'd1;
              r_state  <= S_HDR;
            end else begin
              r_tdata  <= 32'd0;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= S_IDLE;
            end
          end else if (w_hs) begin
            r_idx   <= w_idx_next;
            r_tdata <= w_words[w_idx_next];
            r_tlast <= (w_idx_next == c_LAST_IDX);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Sample during an active frame: park it, or count it as dropped
      if ((r_state != S_IDLE) && !w_last_hs && w_accept) begin
        if (!r_pend_full) begin
          r_pend_ch   <= ch_data_i;
          r_pend_cnt  <= counter_i;
          r_pend_full <= 1'b1;
        end else if (r_dropped != 16'hFFFF) begin
          r_dropped <= r_dropped + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_telemetry_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_telemetry_frame_scheduler
// Description : Directed self-checking bench for telemetry_frame_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_telemetry_frame_scheduler;
  import telemetry_pkg::*;

  localparam int c_N_CH = 22;
  localparam int c_FW   = frame_words(c_N_CH);

  logic                   clk;
  logic                   rst_n;
  logic                   enable_i;
  logic                   sample_valid_i;
  logic [c_N_CH*32-1:0]   ch_data_i;
  logic [31:0]            counter_i;
  logic [31:0]            frames_sent_o;
  logic [15:0]            frames_dropped_o;
  logic                   busy_o;

  int n_checks;
  int n_errors;

  telemetry_frame_scheduler_if bus ();

  telemetry_frame_scheduler #(
    .N_CH  (c_N_CH),
    .MAGIC (16'h4E1C)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_i         (enable_i),
    .sample_valid_i   (sample_valid_i),
    .ch_data_i        (ch_data_i),
    .counter_i        (counter_i),
    .m_axis           (bus.master),
    .frames_sent_o    (frames_sent_o),
    .frames_dropped_o (frames_dropped_o),
    .busy_o           (busy_o)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [c_N_CH*32-1:0] make_ch(input logic [31:0] base);
    logic [c_N_CH*32-1:0] v;
    for (int k = 0; k < c_N_CH; k++) v[32*k +: 32] = base + 32'(k);
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input int w, input logic [7:0] seq,
                                           input logic [31:0] cnt, input logic [31:0] base);
    if (w == 0) return {16'h4E1C, 8'd22, seq};
    if (w == 1) return cnt;
    return base + 32'(w - 2);
  endfunction

  // Pulse one strobe at the next rising edge, then scramble inputs
  task automatic strobe(input logic [31:0] cnt, input logic [31:0] base);
    sample_valid_i = 1'b1;
    counter_i      = cnt;
    ch_data_i      = make_ch(base);
    @(negedge clk);
    sample_valid_i = 1'b0;
    counter_i      = ~cnt;
    ch_data_i      = ~make_ch(base);
  endtask

  // Consume one frame; optionally inject a strobe on the last-word handshake
  task automatic recv_frame(input logic [7:0] seq, input logic [31:0] cnt,
                            input logic [31:0] base, input bit rnd,
                            input bit inject, input logic [31:0] inj_cnt,
                            input logic [31:0] inj_base, output int cycles);
    int w;
    w = 0;
    cycles = 0;
    while (w < c_FW && cycles < 5000) begin
      bus.m_tready_i = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      check("tvalid_held", 32'(bus.m_tvalid_o), 32'd1);
      if (bus.m_tvalid_o) begin
        check($sformatf("seq%0d_w%0d_data", seq, w), bus.m_tdata_o, exp_word(w, seq, cnt, base));
        check($sformatf("seq%0d_w%0d_last", seq, w), 32'(bus.m_tlast_o), 32'(w == c_FW - 1));
        if (bus.m_tready_i) begin
          if (inject && w == c_FW - 1) begin
            sample_valid_i = 1'b1;
            counter_i      = inj_cnt;
            ch_data_i      = make_ch(inj_base);
          end
          w++;
        end
      end
      @(negedge clk);
      cycles++;
    end
    sample_valid_i = 1'b0;
    if (inject) begin
      counter_i = ~inj_cnt;
      ch_data_i = ~make_ch(inj_base);
    end
    if (w < c_FW) check("frame_timeout", 32'(w), 32'(c_FW));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    enable_i       = 1'b1;
    sample_valid_i = 1'b0;
    ch_data_i      = '0;
    counter_i      = 32'd0;
    bus.m_tready_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tvalid",  32'(bus.m_tvalid_o), 32'd0);
    check("rst_tlast",   32'(bus.m_tlast_o),  32'd0);
    check("rst_tdata",   bus.m_tdata_o,       32'd0);
    check("rst_sent",    frames_sent_o,       32'd0);
    check("rst_dropped", 32'(frames_dropped_o), 32'd0);
    check("rst_busy",    32'(busy_o),         32'd0);

    // Full-rate frame: 24 consecutive words, header 0x4E1C1600
    bus.m_tready_i = 1'b1;
    strobe(32'h100, 32'h11000000);
    check("hdr_const", bus.m_tdata_o, 32'h4E1C1600);
    recv_frame(8'd0, 32'h100, 32'h11000000, 1'b0, 1'b0, 32'd0, 32'd0, cyc);
    check("full_rate_cycles", 32'(cyc), 32'd24);
    check("f1_idle_tvalid", 32'(bus.m_tvalid_o), 32'd0);
    check("f1_sent", frames_sent_o, 32'd1);
    check("f1_busy", 32'(busy_o), 32'd0);

    // Random backpressure at ~30% ready
    bus.m_tready_i = 1'b0;
    strobe(32'h200, 32'h22000000);
    recv_frame(8'd1, 32'h200, 32'h22000000, 1'b1, 1'b0, 32'd0, 32'd0, cyc);
    check("f2_sent", frames_sent_o, 32'd2);

    // Pending slot and drop, then back-to-back frames seq 0 and 1
    bus.m_tready_i = 1'b0;
    do_reset();
    strobe(32'h300, 32'h33000000);
    strobe(32'h400, 32'h44000000);
    strobe(32'h500, 32'h55000000);
    check("pend_dropped", 32'(frames_dropped_o), 32'd1);
    check("pend_busy",    32'(busy_o), 32'd1);
    check("pend_hdr_hold", bus.m_tdata_o, 32'h4E1C1600);
    recv_frame(8'd0, 32'h300, 32'h33000000, 1'b0, 1'b0, 32'd0, 32'd0, cyc);
    recv_frame(8'd1, 32'h400, 32'h44000000, 1'b0, 1'b0, 32'd0, 32'd0, cyc);
    check("b2b_sent",    frames_sent_o, 32'd2);
    check("b2b_idle",    32'(bus.m_tvalid_o), 32'd0);
    check("b2b_dropped", 32'(frames_dropped_o), 32'd1);

    // Strobe coincident with last-word handshake, pending empty
    strobe(32'h600, 32'h66000000);
    recv_frame(8'd2, 32'h600, 32'h66000000, 1'b0, 1'b1, 32'h700, 32'h77000000, cyc);
    recv_frame(8'd3, 32'h700, 32'h77000000, 1'b0, 1'b0, 32'd0, 32'd0, cyc);
    check("coinc_sent",    frames_sent_o, 32'd4);
    check("coinc_dropped", 32'(frames_dropped_o), 32'd1);

    // Reset in the middle of a frame at word 10
    strobe(32'h800, 32'h88000000);
    repeat (10) @(negedge clk);
    check("mid_word10", bus.m_tdata_o, 32'h88000008);
    rst_n = 1'b0;
    #1;
    check("arst_tvalid",  32'(bus.m_tvalid_o), 32'd0);
    check("arst_tlast",   32'(bus.m_tlast_o),  32'd0);
    check("arst_tdata",   bus.m_tdata_o,       32'd0);
    check("arst_sent",    frames_sent_o,       32'd0);
    check("arst_dropped", 32'(frames_dropped_o), 32'd0);
    check("arst_busy",    32'(busy_o),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strobe(32'h900, 32'h99000000);
    recv_frame(8'd0, 32'h900, 32'h99000000, 1'b0, 1'b0, 32'd0, 32'd0, cyc);
    check("post_rst_sent", frames_sent_o, 32'd1);

    // Disabled capture ignores strobes without counting drops
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) strobe(32'hA00 + 32'(i), 32'hAA000000);
    @(negedge clk);
    check("dis_tvalid",  32'(bus.m_tvalid_o), 32'd0);
    check("dis_busy",    32'(busy_o), 32'd0);
    check("dis_dropped", 32'(frames_dropped_o), 32'd0);
    check("dis_sent",    frames_sent_o, 32'd1);

    // Drop counter saturation: 70000 drop events
    enable_i       = 1'b1;
    bus.m_tready_i = 1'b0;
    strobe(32'hB00, 32'hBB000000);
    strobe(32'hC00, 32'hCC000000);
    sample_valid_i = 1'b1;
    repeat (65534) @(negedge clk);
    check("drop_65534", 32'(frames_dropped_o), 32'h0000FFFE);
    repeat (2) @(negedge clk);
    check("drop_sat", 32'(frames_dropped_o), 32'h0000FFFF);
    repeat (70000 - 65536) @(negedge clk);
    sample_valid_i = 1'b0;
    check("drop_sat_hold", 32'(frames_dropped_o), 32'h0000FFFF);
    check("drop_hdr_hold", bus.m_tdata_o, 32'h4E1C1601);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/telemetry_frame_scheduler.md
TELEMETRY_FRAME_SCHEDULER -- requirements
Module: telemetry_frame_scheduler

Interface
REQ-001 Parameter N_CH, default 22, SHALL be the number of 32-bit channels per frame (1..255).
REQ-002 Parameter MAGIC, default 16'h4E1C, SHALL be the frame header tag.
REQ-003 clk  in  1  SHALL be the single clock.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 enable_i  in  1  SHALL be the capture enable; samples are ignored when low.
REQ-006 sample_valid_i  in  1  SHALL be a one-cycle strobe marking a new ADC/demod sample set.
REQ-007 ch_data_i  in  N_CH*32  SHALL carry the channel vector; channel k is bits [32k+31:32k].
REQ-008 counter_i  in  32  SHALL carry the free-running sample counter.
REQ-009 m_tdata_o  out  32  SHALL be the stream data word.
REQ-010 m_tvalid_o, m_tlast_o  out  1 each  SHALL be stream valid and last-word flag.
REQ-011 m_tready_i  in  1  SHALL be stream ready from the sink.
REQ-012 frames_sent_o  out  32  SHALL be the completed-frame count.
REQ-013 frames_dropped_o  out  16  SHALL be the dropped-sample count.
REQ-014 busy_o  out  1  SHALL be high while a frame is active or pending.

Function
REQ-015 Frame SHALL be N_CH+2 words: word0 {MAGIC, N_CH[7:0], seq[7:0]}, word1 counter snapshot, words 2..N_CH+1 channels 0..N_CH-1.
REQ-016 Accepted sample SHALL snapshot ch_data_i and counter_i in the strobe cycle; later input changes SHALL not affect that frame.
REQ-017 FSM states SHALL be IDLE, HDR, CNT, CH; IDLE->HDR on accepted sample, HDR->CNT, CNT->CH on handshake, CH->HDR or IDLE after last-channel handshake.
REQ-018 Sample strobe in IDLE at cycle t SHALL produce m_tvalid_o=1 with word0 at t+1.
REQ-019 Word index SHALL advance only on m_tvalid_o & m_tready_i; m_tdata_o and m_tlast_o SHALL hold stable while m_tvalid_o & !m_tready_i.
REQ-020 m_tvalid_o SHALL not deassert before handshake once asserted.
REQ-021 m_tlast_o SHALL be high only on word N_CH+1.
REQ-022 One pending slot SHALL exist; a sample arriving while a frame is active SHALL fill the pending slot if empty, else increment frames_dropped_o.
REQ-023 On the last-word handshake: pending full -> pending becomes active, HDR next cycle with no tvalid gap, and a same-cycle sample fills pending; pending empty and same-cycle sample -> sample becomes active directly; else -> IDLE.
REQ-024 seq SHALL increment by 1 per started frame, wrapping 255->0.
REQ-025 frames_sent_o SHALL increment on each last-word handshake, wrapping at 2^32.
REQ-026 frames_dropped_o SHALL saturate at 16'hFFFF.
REQ-027 enable_i low SHALL ignore new strobes without counting drops; active and pending frames SHALL still complete.

Reset
REQ-028 On rst_n low: state IDLE, pending empty, seq=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, frames_sent_o=0, frames_dropped_o=0, busy_o=0.
REQ-029 Reset mid-frame SHALL abandon the frame immediately with no m_tlast_o emitted.

Structure
REQ-030 Package telemetry_pkg SHALL hold the MAGIC default, the state enum, and frame-length constant FRAME_WORDS(N_CH)=N_CH+2.
REQ-031 The block SHALL be a single module with no sub-modules; the channel word mux SHALL be indexed from the active snapshot register.

Verification
REQ-032 N_CH=22, tready=1, strobe with counter_i=0x100 -> 24 words on consecutive cycles, word0=0x4E1C1600, word1=0x100, tlast on word 23, frames_sent=1.
REQ-033 Random tready at 30% duty -> data and tlast stable during stalls, words in order, no loss.
REQ-034 tready=0, three strobes during frame -> second goes to pending, third gives frames_dropped=1; after release two frames with seq 0 and 1 back-to-back, no tvalid gap.
REQ-035 Strobe coincident with last-word handshake, pending empty -> next frame header on following cycle with that sample's counter.
REQ-036 rst_n low at word 10 -> all outputs zero asynchronously; new strobe after release -> frame with seq=0.
REQ-037 enable_i=0, 5 strobes -> no frames, frames_dropped=0; 70000 drop events -> frames_dropped=0xFFFF.
